// File: rtl/wb_ram_arbiter.sv
// Two-port Wishbone slave arbiter in front of a single-port synchronous RAM.
// Each transfer is IDLE -> SETUP -> READ -> ACK, with round-robin arbitration on contention.
module wb_ram_arbiter #(
  parameter int RAM_AW = 11
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [3:0]        m0_sel_i,
  input  logic [31:0]       m0_adr_i,
  input  logic [31:0]       m0_dat_i,
  output logic [31:0]       m0_dat_o,
  output logic              m0_ack_o,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [3:0]        m1_sel_i,
  input  logic [31:0]       m1_adr_i,
  input  logic [31:0]       m1_dat_i,
  output logic [31:0]       m1_dat_o,
  output logic              m1_ack_o,
  output logic [RAM_AW-1:0] ram_addr_o,
  output logic [31:0]       ram_data_o,
  output logic [3:0]        ram_byteena_o,
  output logic              ram_wren_o,
  input  logic [31:0]       ram_q_i
);

  typedef enum logic [1:0] {IDLE, SETUP, READ, ACK} state_t;

  state_t state, state_nx;
  logic   req0, req1, any_req;
  logic   grant, last_grant, grant_nx, grant_cyc;

  assign req0      = m0_cyc_i & m0_stb_i;
  assign req1      = m1_cyc_i & m1_stb_i;
  assign any_req   = req0 | req1;
  assign grant_cyc = grant ? m1_cyc_i : m0_cyc_i;

  // Byte-lane bits and bits above the RAM window alias away.
  logic unused_adr;
  assign unused_adr = ^{m0_adr_i[31:RAM_AW+2], m0_adr_i[1:0],
                        m1_adr_i[31:RAM_AW+2], m1_adr_i[1:0]};

  always_comb begin
    grant_nx = 1'b0;
    if (req0 && req1) grant_nx = ~last_grant;
    else if (req1)    grant_nx = 1'b1;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = SETUP;
      SETUP:   state_nx = READ;
      READ:    state_nx = grant_cyc ? ACK : IDLE;
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      grant         <= 1'b0;
      last_grant    <= 1'b1;
      ram_addr_o    <= '0;
      ram_data_o    <= '0;
      ram_byteena_o <= '0;
      ram_wren_o    <= 1'b0;
      m0_dat_o      <= '0;
      m1_dat_o      <= '0;
      m0_ack_o      <= 1'b0;
      m1_ack_o      <= 1'b0;
    end else begin
      ram_wren_o <= 1'b0;
      m0_ack_o   <= 1'b0;
      m1_ack_o   <= 1'b0;
      if (state == IDLE && any_req) begin
        grant      <= grant_nx;
        last_grant <= grant_nx;
        if (grant_nx) begin
          ram_addr_o    <= m1_adr_i[RAM_AW+1:2];
          ram_data_o    <= m1_dat_i;
          ram_byteena_o <= m1_sel_i;
          ram_wren_o    <= m1_we_i;
        end else begin
          ram_addr_o    <= m0_adr_i[RAM_AW+1:2];
          ram_data_o    <= m0_dat_i;
          ram_byteena_o <= m0_sel_i;
          ram_wren_o    <= m0_we_i;
        end
      end
      // RAM data is valid in READ; capture it for reads and writes alike.
      if (state == READ && grant_cyc) begin
        if (grant) begin
          m1_dat_o <= ram_q_i;
          m1_ack_o <= 1'b1;
        end else begin
          m0_dat_o <= ram_q_i;
          m0_ack_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Self-checking bench for wb_ram_arbiter: behavioural RAM, two bus masters,
// and a scoreboard of expected acks (master + read data) checked as they appear.
module tb_wb_ram_arbiter;

  localparam int RAM_AW = 11;

  logic              clk_i = 1'b0;
  logic              rst_n_i;
  logic [1:0]        cyc, stb, we, ack;
  logic [3:0]        sel [2];
  logic [31:0]       adr [2];
  logic [31:0]       wdat[2];
  logic [31:0]       dout[2];
  logic [RAM_AW-1:0] ram_addr_o;
  logic [31:0]       ram_data_o, ram_q;
  logic [3:0]        ram_byteena_o;
  logic              ram_wren_o;

  wb_ram_arbiter #(.RAM_AW(RAM_AW)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_sel_i(sel[0]),
    .m0_adr_i(adr[0]), .m0_dat_i(wdat[0]), .m0_dat_o(dout[0]), .m0_ack_o(ack[0]),
    .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_sel_i(sel[1]),
    .m1_adr_i(adr[1]), .m1_dat_i(wdat[1]), .m1_dat_o(dout[1]), .m1_ack_o(ack[1]),
    .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o), .ram_byteena_o(ram_byteena_o),
    .ram_wren_o(ram_wren_o), .ram_q_i(ram_q)
  );

  always #5 clk_i = ~clk_i;

  // Single-port synchronous RAM with byte enables.
  logic [31:0] mem [0:(1<<RAM_AW)-1];
  always @(posedge clk_i) begin
    if (ram_wren_o)
      for (int b = 0; b < 4; b++)
        if (ram_byteena_o[b]) mem[ram_addr_o][8*b +: 8] <= ram_data_o[8*b +: 8];
    ram_q <= mem[ram_addr_o];
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct packed { logic m; logic rd; logic [31:0] dat; } sb_t;
  sb_t sbq[$];
  sb_t e;

  int               wr_cnt = 0;
  logic [RAM_AW-1:0] wr_addr;
  logic [3:0]       wr_be;

  always @(negedge clk_i) if (rst_n_i === 1'b1) begin
    if (ram_wren_o) begin
      wr_cnt++;
      wr_addr = ram_addr_o;
      wr_be   = ram_byteena_o;
    end
    if (ack[0] && ack[1]) chk("both_ack", 32'(ack), 32'h1);
    else if (|ack) begin
      if (sbq.size() == 0) chk("unexp_ack", 32'(ack), 32'h0);
      else begin
        e = sbq.pop_front();
        chk("grant", 32'(ack[1]), 32'(e.m));
        if (e.rd) chk("rdata", dout[ack[1]], e.dat);
      end
    end
  end

  task automatic xfer(input int m, input logic w, input logic [31:0] a,
                      input logic [3:0] s, input logic [31:0] d, output int lat);
    @(posedge clk_i); #1;
    cyc[m] = 1'b1; stb[m] = 1'b1; we[m] = w; adr[m] = a; sel[m] = s; wdat[m] = d;
    lat = 0;
    while (ack[m] !== 1'b1 && lat < 20) begin
      @(posedge clk_i); #1;
      lat++;
    end
    if (lat >= 20) chk("ack_timeout", 32'(lat), 32'd3);
    cyc[m] = 1'b0; stb[m] = 1'b0; we[m] = 1'b0;
  endtask

  task automatic wr(input int m, input logic [31:0] a, input logic [3:0] s,
                    input logic [31:0] d, output int lat);
    sbq.push_back('{m: 1'(m), rd: 1'b0, dat: 32'h0});
    xfer(m, 1'b1, a, s, d, lat);
  endtask

  task automatic rd(input int m, input logic [31:0] a, input logic [31:0] exp, output int lat);
    sbq.push_back('{m: 1'(m), rd: 1'b1, dat: exp});
    xfer(m, 1'b0, a, 4'hF, 32'h0, lat);
  endtask

  logic [31:0] sh [16];
  int lat, lat0, lat1, n, wi, mm;
  logic [31:0] d, a;
  logic [3:0]  s;

  initial begin
    for (int i = 0; i < (1<<RAM_AW); i++) mem[i] = 32'h0;
    rst_n_i = 1'b0;
    cyc = '0; stb = '0; we = '0;
    for (int i = 0; i < 2; i++) begin adr[i] = '0; sel[i] = '0; wdat[i] = '0; end
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ack",  32'(ack), 32'h0);
    chk("rst_wren", 32'(ram_wren_o), 32'h0);
    chk("rst_addr", 32'(ram_addr_o), 32'h0);
    chk("rst_data", ram_data_o, 32'h0);
    chk("rst_be",   32'(ram_byteena_o), 32'h0);
    chk("rst_dat0", dout[0], 32'h0);
    chk("rst_dat1", dout[1], 32'h0);
    rst_n_i = 1'b1;

    // Contention right after reset: grants alternate m0, m1, m0, m1.
    sbq.push_back('{m: 1'b0, rd: 1'b0, dat: 32'h0});
    sbq.push_back('{m: 1'b1, rd: 1'b0, dat: 32'h0});
    sbq.push_back('{m: 1'b0, rd: 1'b1, dat: 32'hB0B0_0044});
    sbq.push_back('{m: 1'b1, rd: 1'b1, dat: 32'hA0A0_0040});
    fork
      begin xfer(0, 1'b1, 32'h40, 4'hF, 32'hA0A0_0040, lat0); xfer(0, 1'b0, 32'h44, 4'hF, 0, lat0); end
      begin xfer(1, 1'b1, 32'h44, 4'hF, 32'hB0B0_0044, lat1); xfer(1, 1'b0, 32'h40, 4'hF, 0, lat1); end
    join

    // Full-word write, latency, single write strobe, word addressing.
    wr_cnt = 0;
    wr(0, 32'h10, 4'hF, 32'hDEADBEEF, lat);
    chk("wr_lat",  32'(lat), 32'd3);
    chk("wr_cnt",  32'(wr_cnt), 32'd1);
    chk("wr_addr", 32'(wr_addr), 32'd4);
    rd(0, 32'h10, 32'hDEADBEEF, lat);
    chk("rd_lat", 32'(lat), 32'd3);

    // Byte-enabled write from m1.
    wr(1, 32'h10, 4'h2, 32'h0000AB00, lat);
    chk("wr_be", 32'(wr_be), 32'h2);
    rd(1, 32'h10, 32'hDEADABEF, lat);

    // Aliasing above the RAM window.
    wr(0, 32'h2000, 4'hF, 32'h12345678, lat);
    chk("alias_addr", 32'(wr_addr), 32'h0);
    rd(1, 32'h0, 32'h12345678, lat);

    // m1 aborts during READ while m0 is requesting.
    sbq.push_back('{m: 1'b0, rd: 1'b1, dat: 32'h12345678});
    @(posedge clk_i); #1;
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; adr[1] = 32'h40; sel[1] = 4'hF;
    @(posedge clk_i); @(posedge clk_i); #1;
    cyc[1] = 1'b0; stb[1] = 1'b0;
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 32'h0; sel[0] = 4'hF;
    @(posedge clk_i); #1;
    chk("abort_noack", 32'(ack), 32'h0);
    n = 0;
    while (ack[0] !== 1'b1 && n < 20) begin @(posedge clk_i); #1; n++; end
    chk("abort_m0_lat", 32'(n), 32'd3);
    cyc[0] = 1'b0; stb[0] = 1'b0;

    // Random traffic on 16 words with aliased upper bits and random byte lanes.
    for (int i = 0; i < 16; i++) begin
      sh[i] = $urandom;
      wr(i % 2, ($urandom & 32'hFFFF_E000) | 32'h100 | (32'(i) << 2) | 32'($urandom_range(0, 3)),
         4'hF, sh[i], lat);
    end
    for (int k = 0; k < 24; k++) begin
      wi = $urandom_range(0, 15);
      mm = $urandom_range(0, 1);
      a  = ($urandom & 32'hFFFF_E000) | 32'h100 | (32'(wi) << 2);
      if ($urandom_range(0, 1) == 1) begin
        s = 4'($urandom_range(1, 15));
        d = $urandom;
        for (int b = 0; b < 4; b++) if (s[b]) sh[wi][8*b +: 8] = d[8*b +: 8];
        wr(mm, a, s, d, lat);
      end else begin
        rd(mm, a, sh[wi], lat);
      end
    end

    // Reset during SETUP of a write clears strobes immediately.
    @(posedge clk_i); #1;
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 32'h20; sel[0] = 4'hF; wdat[0] = 32'h55555555;
    @(posedge clk_i); #1;
    chk("setup_wren", 32'(ram_wren_o), 32'h1);
    #2 rst_n_i = 1'b0;
    #1;
    chk("arst_wren", 32'(ram_wren_o), 32'h0);
    chk("arst_ack",  32'(ack), 32'h0);
    chk("arst_addr", 32'(ram_addr_o), 32'h0);
    cyc[0] = 1'b0; stb[0] = 1'b0; we[0] = 1'b0;
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    sbq.push_back('{m: 1'b0, rd: 1'b1, dat: 32'hA0A0_0040});
    sbq.push_back('{m: 1'b1, rd: 1'b1, dat: 32'h0});
    fork
      xfer(0, 1'b0, 32'h40, 4'hF, 0, lat0);
      xfer(1, 1'b0, 32'h20, 4'hF, 0, lat1);
    join

    repeat (3) @(posedge clk_i);
    #1;
    chk("sb_empty", 32'(sbq.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
